if_fetch: RTL

Instruction fetch unit for the tinyRV32 core. It owns the program counter and issues word reads to instruction memory over a req/gnt/rvalid handshake. Returned words go into a small prefetch FIFO, and the FIFO head is presented as the instruction/address pair consumed by the IF/ID stage. It honours the pipeline hold from the control unit and redirects on jumps, discarding any in-flight fetch from the old path.

---
 rtl/if_fetch.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction fetch unit: owns the PC, keeps at most one word read outstanding
// and buffers returned words in a small prefetch FIFO whose head feeds IF/ID.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hold_flag_i,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        inst_valid_o
);
   localparam int          AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          CW  = AW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [31:0]    r_pc;
   logic [31:0]    r_req_addr;
   logic [31:0]    r_out_addr;
   logic           r_drop;
   logic           r_stale;
   logic [CW-1:0]  r_count;
   logic [AW-1:0]  r_wptr;
   logic [AW-1:0]  r_rptr;
   logic [31:0]    r_fifo_addr [DEPTH];
   logic [31:0]    r_fifo_inst [DEPTH];

   logic [31:0]    w_jaddr;
   logic           w_valid;
   logic           w_pop;
   logic           w_in_wait;
   logic           w_resp;
   logic           w_push;
   logic [CW:0]    w_occ;
   logic           w_room;
   logic           w_req;
   logic [31:0]    w_addr;
   logic           w_gnt;
   logic           w_new_gnt;

   assign w_jaddr   = jump_addr_i & ~32'd3;
   assign w_valid   = (r_count != '0);
   assign w_pop     = w_valid & ~hold_flag_i & ~jump_flag_i;
   assign w_in_wait = (r_state == S_WAIT);
   assign w_resp    = w_in_wait & mem_rvalid_i;
   assign w_push    = w_resp & ~r_drop & ~jump_flag_i;

   // The outstanding fetch always reserves a slot, even if it will be dropped.
   assign w_occ  = {1'b0, r_count} + {{CW{1'b0}}, w_in_wait} - {{CW{1'b0}}, w_pop};
   assign w_room = jump_flag_i | (w_occ < (CW+1)'(DEPTH));

   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      w_addr      = jump_flag_i ? w_jaddr : r_pc;
      case (r_state)
         S_IDLE: begin
            if (w_room & ~rst) begin
               w_req       = 1'b1;
               w_state_nxt = mem_gnt_i ? S_WAIT : S_REQ;
            end
         end
         S_REQ: begin
            w_req  = 1'b1;
            w_addr = r_req_addr;
            if (mem_gnt_i) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rvalid_i) begin
               if (w_room) begin
                  w_req       = 1'b1;
                  w_state_nxt = mem_gnt_i ? S_WAIT : S_REQ;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_gnt     = w_req & mem_gnt_i;
   assign w_new_gnt = w_gnt & (r_state != S_REQ);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_drop  <= 1'b0;
         r_stale <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         // A request launched this cycle already carries the jump target.
         if (w_new_gnt)
            r_pc <= w_addr + 32'd4;
         else if (jump_flag_i)
            r_pc <= w_jaddr;
         else if (w_gnt & ~r_stale)
            r_pc <= w_addr + 32'd4;

         r_stale <= (r_state == S_REQ) & ~w_gnt & (r_stale | jump_flag_i);

         if (w_gnt)
            r_drop <= (r_state == S_REQ) & (jump_flag_i | r_stale);
         else if (w_resp)
            r_drop <= 1'b0;
         else if (jump_flag_i & w_in_wait)
            r_drop <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
      end else if (jump_flag_i) begin
         r_count <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         r_count <= r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (w_gnt) r_out_addr <= w_addr;
      if (w_req & ~mem_gnt_i & (r_state != S_REQ)) r_req_addr <= w_addr;
      if (w_push) begin
         r_fifo_addr[r_wptr] <= r_out_addr;
         r_fifo_inst[r_wptr] <= mem_rdata_i;
      end
   end

   assign mem_req_o    = w_req;
   assign mem_addr_o   = w_addr;
   assign inst_valid_o = w_valid;
   assign inst_o       = w_valid ? r_fifo_inst[r_rptr] : NOP;
   assign inst_addr_o  = w_valid ? r_fifo_addr[r_rptr] : 32'h0;

endmodule
